// File: rtl/ram_responder.sv
// Data-memory responder: word RAM with byte-lane writes, plus an MMIO page
// holding a console TX FIFO, a status register and a free-running cycle counter.
module ram_responder #(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ram_r,
  input  logic [3:0]  ram_w,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_out,
  output logic [31:0] ram_in,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        bus_err
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [29:0] TX_WA = MMIO_BASE[31:2];
  localparam logic [29:0] ST_WA = TX_WA + 30'd1;
  localparam logic [29:0] CY_WA = TX_WA + 30'd2;

  logic [31:0] mem [RAM_WORDS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  logic [29:0]   word_addr;
  logic          ram_hit, tx_hit, st_hit, cy_hit, unmapped;
  logic [PW:0]   count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          overflow, full, empty;
  logic          push_req, push_ok, pop;
  logic [31:0]   cycle;
  logic [7:0]    count8;
  logic [31:0]   status;
  logic          unused_addr_lsbs;

  assign word_addr        = ram_addr[31:2];
  assign unused_addr_lsbs = &{1'b0, ram_addr[1:0]};

  assign ram_hit  = (ram_addr[31:AW+2] == '0);
  assign tx_hit   = (word_addr == TX_WA);
  assign st_hit   = (word_addr == ST_WA);
  assign cy_hit   = (word_addr == CY_WA);
  assign unmapped = !(ram_hit || tx_hit || st_hit || cy_hit) && (ram_r || (ram_w != 4'b0000));

  assign full     = (count == (PW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign tx_valid = !empty;
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign pop      = tx_valid && tx_ready;
  assign push_req = tx_hit && ram_w[0];
  assign push_ok  = push_req && (!full || pop);

  assign count8 = 8'(count);
  assign status = {16'b0, count8, 5'b0, overflow, empty, full};

  always_comb begin
    ram_in = 32'h0;
    if (ram_r) begin
      if (ram_hit)     ram_in = mem[ram_addr[AW+1:2]];
      else if (st_hit) ram_in = status;
      else if (cy_hit) ram_in = cycle;
    end
  end

  // RAM and FIFO storage carry no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_w[i]) mem[ram_addr[AW+1:2]][8*i +: 8] <= ram_out[8*i +: 8];
      end
    end
    if (push_ok) fifo_mem[wr_ptr] <= ram_out[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
      cycle    <= 32'h0;
      bus_err  <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;
      if (unmapped) bus_err <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)      count <= count + (PW+1)'(1);
      else if (!push_ok && pop) count <= count - (PW+1)'(1);
      if (push_req && !push_ok)                    overflow <= 1'b1;
      else if (st_hit && ram_w[0] && ram_out[2])   overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Randomized bench for ram_responder against a queue/array reference model.
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ram_r = 1'b0;
  logic [3:0]  ram_w = 4'h0;
  logic [31:0] ram_addr = 32'h0;
  logic [31:0] ram_out = 32'h0;
  logic [31:0] ram_in;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        bus_err;

  ram_responder #(.RAM_WORDS(1024), .FIFO_DEPTH(16), .MMIO_BASE(32'hFFFF_FF00)) dut (
    .clk(clk), .rst_n(rst_n), .ram_r(ram_r), .ram_w(ram_w), .ram_addr(ram_addr),
    .ram_out(ram_out), .ram_in(ram_in), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // reference model state; only the low 64 RAM words are exercised
  logic [31:0] m_mem [64];
  logic [7:0]  m_q [$];
  logic        m_ovf = 1'b0;
  logic        m_berr = 1'b0;
  logic [31:0] m_cyc = 32'h0;

  logic [31:0] last_rd;
  logic        last_valid;
  logic [7:0]  last_data;
  logic        last_berr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // 0 RAM, 1 TXDATA, 2 STATUS, 3 CYCLE, 4 unmapped
  function automatic int region(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (a < 32'd4096)           return 0;
    if (wa == 32'hFFFF_FF00)    return 1;
    if (wa == 32'hFFFF_FF04)    return 2;
    if (wa == 32'hFFFF_FF08)    return 3;
    return 4;
  endfunction

  function automatic logic [31:0] m_read(input logic r, input logic [31:0] a);
    int n;
    n = m_q.size();
    if (!r) return 32'h0;
    case (region(a))
      0: return m_mem[a[7:2]];
      2: return {16'h0, 8'(n), 5'b0, m_ovf, n == 0, n == 16};
      3: return m_cyc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_ovf  = 1'b0;
    m_berr = 1'b0;
    m_cyc  = 32'h0;
  endfunction

  // Starts and ends at a falling edge; checks outputs mid-cycle, then applies the edge to the model.
  task automatic step(input logic r, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy);
    logic pop;
    int   rg;
    ram_r = r; ram_w = w; ram_addr = a; ram_out = d; tx_ready = rdy;
    #1;
    last_rd = ram_in; last_valid = tx_valid; last_data = tx_data; last_berr = bus_err;
    chk("ram_in",   ram_in,   m_read(r, a));
    chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
    chk("tx_data",  32'(tx_data),  (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
    chk("bus_err",  32'(bus_err),  32'(m_berr));
    @(posedge clk);
    if (rst_n) begin
      rg  = region(a);
      pop = (m_q.size() != 0) && rdy;
      if (pop) void'(m_q.pop_front());
      if (rg == 1 && w[0]) begin
        if (m_q.size() < 16) m_q.push_back(d[7:0]);
        else m_ovf = 1'b1;
      end
      if (rg == 2 && w[0] && d[2]) m_ovf = 1'b0;
      if (rg == 0) for (int i = 0; i < 4; i++) if (w[i]) m_mem[a[7:2]][8*i +: 8] = d[8*i +: 8];
      if (rg == 4 && (r || w != 4'h0)) m_berr = 1'b1;
      m_cyc = m_cyc + 32'd1;
    end
    @(negedge clk);
  endtask

  localparam logic [31:0] TXA = 32'hFFFF_FF00;
  localparam logic [31:0] STA = 32'hFFFF_FF04;
  localparam logic [31:0] CYA = 32'hFFFF_FF08;

  initial begin
    logic [31:0] c1, a, d;
    int k;
    @(negedge clk);
    @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_bus_err",  32'(bus_err),  32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) step(1'b0, 4'hF, 32'(i*4), $urandom, 1'b0);

    // byte-lane write
    step(1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
    step(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    chk("rd_full", last_rd, 32'hDEADBEEF);
    step(1'b1, 4'b0001, 32'h10, 32'h000000AA, 1'b0);
    chk("rd_old_on_write", last_rd, 32'hDEADBEEF);
    step(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    chk("rd_lane0", last_rd, 32'hDEADBEAA);

    // two-byte push and drain
    step(1'b0, 4'h1, TXA, 32'h48, 1'b0);
    step(1'b0, 4'h1, TXA, 32'h69, 1'b0);
    step(1'b1, 4'h0, STA, 32'h0, 1'b0);
    chk("status_two", last_rd, 32'h0000_0200);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    chk("head_h", 32'(last_data), 32'h48);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    chk("head_i", 32'(last_data), 32'h69);
    step(1'b1, 4'h0, STA, 32'h0, 1'b1);
    chk("drained_valid", 32'(last_valid), 32'h0);
    chk("status_empty", last_rd, 32'h0000_0002);

    // fill, overflow, clear, push+pop while full
    for (int i = 0; i < 16; i++) step(1'b0, 4'h1, TXA, 32'(8'h30 + i), 1'b0);
    step(1'b0, 4'h1, TXA, 32'hEE, 1'b0);
    step(1'b1, 4'h0, STA, 32'h0, 1'b0);
    chk("status_ovf", last_rd, 32'h0000_1005);
    step(1'b0, 4'h1, STA, 32'h4, 1'b0);
    step(1'b1, 4'h0, STA, 32'h0, 1'b0);
    chk("status_clr", last_rd, 32'h0000_1001);
    step(1'b0, 4'h1, TXA, 32'h77, 1'b1);
    step(1'b1, 4'h0, STA, 32'h0, 1'b0);
    chk("status_full_pp", last_rd, 32'h0000_1001);
    for (int i = 0; i < 16; i++) step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    chk("last_byte", 32'(last_data), 32'h77);

    // cycle counter spacing
    step(1'b1, 4'h0, CYA, 32'h0, 1'b0);
    c1 = last_rd;
    for (int i = 0; i < 7; i++) step(1'b0, 4'h1, CYA, $urandom, 1'b0);
    step(1'b1, 4'h0, CYA, 32'h0, 1'b0);
    chk("cycle_diff", last_rd - c1, 32'd8);

    // unmapped access is sticky
    step(1'b1, 4'h0, 32'h8000_0000, 32'h0, 1'b0);
    chk("unmapped_rd", last_rd, 32'h0);
    step(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    chk("berr_set", 32'(last_berr), 32'h1);
    step(1'b0, 4'hF, 32'h20, 32'h1234_5678, 1'b0);
    chk("berr_sticky", 32'(last_berr), 32'h1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      k = $urandom_range(0, 99);
      if (k < 55)      a = 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(0, 3));
      else if (k < 92) a = 32'hFFFF_FF00 + 32'($urandom_range(0, 2) * 4);
      else if (k < 96) a = 32'hFFFF_FF0C;
      else             a = 32'h0000_1000 + ($urandom & 32'h0FFF_FFFC);
      d = $urandom;
      step(1'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0, a, d,
           ($urandom_range(0, 3) != 0));
      if (n == 1500) begin
        // reset mid-run with a nonempty FIFO
        for (int i = 0; i < 3; i++) step(1'b0, 4'h1, TXA, 32'(8'h61 + i), 1'b0);
        ram_r = 1'b0; ram_w = 4'h0; tx_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(tx_valid), 32'h0);
        chk("mid_rst_berr",  32'(bus_err),  32'h0);
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 4'h0, CYA, 32'h0, 1'b0);
        chk("cycle_restart", last_rd, 32'h0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
